// File: rtl/pool_seq_ctrl.sv
// pool_seq_ctrl: pooling datapath control/config word sequencer; POOL_CTRL_PAD_EN enables appended zero pad rows
module pool_seq_ctrl #(
  parameter int NUM_PE          = 4,
  parameter int CTRL_WIDTH      = 7,
  parameter int CFG_WIDTH       = 3,
  parameter int STRIDE_WIDTH    = 2,
  parameter int COUNTER_WIDTH   = 4,
  parameter int ROW_COUNT_WIDTH = 6,
  parameter int SHIFT_LAT       = 2,
  parameter int RF_POP_LAT      = 2,
  parameter int OUT_LAT         = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       cfg_kernel3,
  input  logic [STRIDE_WIDTH-1:0]    cfg_stride,
  input  logic [COUNTER_WIDTH-1:0]   cfg_words_per_row,
  input  logic [ROW_COUNT_WIDTH-1:0] cfg_out_rows,
  input  logic [1:0]                 cfg_pad_rows,
  input  logic                       pool_ready,
  input  logic                       out_ready,
  output logic [CTRL_WIDTH-1:0]      ctrl,
  output logic [CFG_WIDTH-1:0]       cfg,
  output logic                       busy,
  output logic                       done
);
  localparam logic [2:0] IDLE = 3'd0, WAIT = 3'd1, ISSUE = 3'd2, DRAIN = 3'd3, DONE = 3'd4;
  localparam int SW = $clog2(NUM_PE);
  localparam int DW = $clog2(OUT_LAT + 1);
  localparam int RW = ROW_COUNT_WIDTH + 2;
  logic [2:0] state;
  logic k3_l, bub;
  logic [STRIDE_WIDTH-1:0] stride_l;
  logic [COUNTER_WIDTH-1:0] words_l, word_cnt;
  logic [ROW_COUNT_WIDTH-1:0] rows_l, orow;
  logic [1:0] krow, kmax;
  logic [SW-1:0] slot, slot_last;
  logic [DW-1:0] dcnt;
  logic [SHIFT_LAT-1:0] sh_dl;
  logic [RF_POP_LAT-1:0] rf_dl;
  logic [OUT_LAT-1:0] mux_dl, push_dl, val_dl;
  logic issue, word_end, k_first, k_last, w_last, r_last, layer_last, pad_cur;
  assign kmax = k3_l ? 2'd2 : 2'd1;
  assign slot_last = (stride_l == STRIDE_WIDTH'(2)) ? SW'(NUM_PE / 2 - 1) : SW'(NUM_PE - 1);
  assign issue = state == ISSUE;
  assign word_end = issue && slot == slot_last;
  assign k_first = krow == 2'd0;
  assign k_last = krow == kmax;
  assign w_last = word_cnt == words_l - COUNTER_WIDTH'(1);
  assign r_last = orow == rows_l - ROW_COUNT_WIDTH'(1);
  assign layer_last = w_last && k_last && r_last;
`ifdef POOL_CTRL_PAD_EN
  logic [1:0] pad_l;
  logic [RW-1:0] irow, real_rows;
  assign real_rows = RW'(rows_l) * (k3_l ? RW'(3) : RW'(2)) - RW'(pad_l);
  assign pad_cur = irow >= real_rows;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pad_l <= '0;
      irow <= '0;
    end else if (state == IDLE && start) begin
      pad_l <= cfg_pad_rows;
      irow <= '0;
    end else if (word_end && w_last) irow <= irow + RW'(1);
`else
  logic unused_pad;
  assign unused_pad = ^cfg_pad_rows;
  assign pad_cur = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      k3_l <= 1'b0;
      stride_l <= '0;
      words_l <= '0;
      rows_l <= '0;
      word_cnt <= '0;
      krow <= '0;
      orow <= '0;
      slot <= '0;
      dcnt <= '0;
      bub <= 1'b0;
    end else
      case (state)
        IDLE: if (start) begin
          k3_l <= cfg_kernel3;
          stride_l <= cfg_stride;
          words_l <= cfg_words_per_row;
          rows_l <= cfg_out_rows;
          word_cnt <= '0;
          krow <= '0;
          orow <= '0;
          bub <= 1'b0;
          state <= (cfg_words_per_row == '0 || cfg_out_rows == '0) ? DONE : WAIT;
        end
        WAIT: if (bub) bub <= 1'b0;
          else if ((pool_ready || pad_cur) && out_ready) begin
            slot <= '0;
            state <= ISSUE;
          end
        ISSUE: if (!word_end) slot <= slot + SW'(1);
          else begin
            word_cnt <= w_last ? '0 : word_cnt + COUNTER_WIDTH'(1);
            krow <= !w_last ? krow : k_last ? 2'd0 : krow + 2'd1;
            orow <= (w_last && k_last) ? orow + ROW_COUNT_WIDTH'(1) : orow;
            bub <= slot_last == '0;
            dcnt <= '0;
            state <= layer_last ? DRAIN : WAIT;
          end
        DRAIN: begin
          dcnt <= dcnt + DW'(1);
          if (dcnt == DW'(OUT_LAT - 1)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sh_dl <= '0;
      rf_dl <= '0;
      mux_dl <= '0;
      push_dl <= '0;
      val_dl <= '0;
    end else begin
      sh_dl <= (sh_dl << 1) | SHIFT_LAT'(issue && slot != '0);
      rf_dl <= (rf_dl << 1) | RF_POP_LAT'(issue && !k_first);
      mux_dl <= (mux_dl << 1) | OUT_LAT'(issue && k_first);
      push_dl <= (push_dl << 1) | OUT_LAT'(issue && !k_last);
      val_dl <= (val_dl << 1) | OUT_LAT'(issue && k_last);
    end
  assign ctrl = {issue && pad_cur, val_dl[OUT_LAT-1], mux_dl[OUT_LAT-1], rf_dl[RF_POP_LAT-1],
                 push_dl[OUT_LAT-1], issue && slot == '0, sh_dl[SHIFT_LAT-1]};
  assign cfg = {k3_l, stride_l};
  assign busy = (state == IDLE && start) || state == WAIT || state == ISSUE || state == DRAIN;
  assign done = state == DONE;
endmodule

// File: tb/tb_pool_seq_ctrl.sv
// tb_pool_seq_ctrl: table-driven checks of pool_seq_ctrl layer sequencing, stalls, reset and zero configs
module tb_pool_seq_ctrl;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, cfg_kernel3 = 1'b0, pool_ready = 1'b1, out_ready = 1'b1;
  logic [1:0] cfg_stride = '0, cfg_pad_rows = '0;
  logic [3:0] cfg_words_per_row = '0;
  logic [5:0] cfg_out_rows = '0;
  logic [6:0] ctrl;
  logic [2:0] cfg;
  logic busy, done;
  int total = 0, bad = 0;
  string bn[7] = '{"shift", "pop", "push", "rfpop", "mux", "valid", "pad"};
  typedef struct {
    string nm;
    logic k3;
    logic [1:0] st;
    logic [3:0] w;
    logic [5:0] r;
    logic [1:0] pad;
    int prl, prh, orl, orh, cyc;
    logic [6:0][7:0] e;
    int fv, lv, p1c;
    logic [6:0] p1v;
    int p2c;
    logic [6:0] p2v;
    bit sad;
  } vec_t;
  vec_t vecs[$];
  pool_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .cfg_kernel3(cfg_kernel3), .cfg_stride(cfg_stride),
    .cfg_words_per_row(cfg_words_per_row), .cfg_out_rows(cfg_out_rows), .cfg_pad_rows(cfg_pad_rows),
    .pool_ready(pool_ready), .out_ready(out_ready), .ctrl(ctrl), .cfg(cfg), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic chkv(input string nm, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(input string nm, input logic k3, input logic [1:0] st, input logic [3:0] w,
      input logic [5:0] r, input logic [1:0] pad, input int prl, input int prh, input int orl, input int orh,
      input int cyc, input logic [6:0][7:0] e, input int fv, input int lv, input int p1c, input logic [6:0] p1v,
      input int p2c, input logic [6:0] p2v, input bit sad);
    vec_t v;
    v.nm = nm; v.k3 = k3; v.st = st; v.w = w; v.r = r; v.pad = pad;
    v.prl = prl; v.prh = prh; v.orl = orl; v.orh = orh; v.cyc = cyc; v.e = e;
    v.fv = fv; v.lv = lv; v.p1c = p1c; v.p1v = p1v; v.p2c = p2c; v.p2v = p2v; v.sad = sad;
    return v;
  endfunction
  task automatic run(input vec_t v);
    int cyc, fv, lv, gap, act;
    int cnt[7];
    logic [6:0] p1, p2;
    bit seen;
    cfg_kernel3 = v.k3; cfg_stride = v.st; cfg_words_per_row = v.w; cfg_out_rows = v.r; cfg_pad_rows = v.pad;
    pool_ready = 1'b1; out_ready = 1'b1; start = 1'b1;
    #1 chk({v.nm, ".busy_on_start"}, busy, 1);
    @(posedge clk);
    #1 start = 1'b0;
    cfg_kernel3 = ~v.k3; cfg_stride = ~v.st; cfg_words_per_row = ~v.w; cfg_out_rows = ~v.r; cfg_pad_rows = ~v.pad;
    cyc = 0; fv = 0; lv = 0; gap = 0; seen = 1'b0; p1 = 'x; p2 = 'x;
    for (int b = 0; b < 7; b++) cnt[b] = 0;
    while (!seen && cyc < 400) begin
      @(negedge clk);
      cyc++;
      pool_ready = !(cyc >= v.prl && cyc <= v.prh);
      out_ready = !(cyc >= v.orl && cyc <= v.orh);
      for (int b = 0; b < 7; b++) if (ctrl[b]) cnt[b]++;
      if (ctrl[5]) begin
        if (fv == 0) fv = cyc;
        lv = cyc;
      end
      if (!done && !busy) gap++;
      if (cyc == v.p1c) p1 = ctrl;
      if (cyc == v.p2c) p2 = ctrl;
      seen = done;
    end
    pool_ready = 1'b1; out_ready = 1'b1;
    chk({v.nm, ".done_seen"}, int'(seen), 1);
    chk({v.nm, ".cycles"}, cyc, v.cyc);
    for (int b = 0; b < 7; b++) chk({v.nm, ".", bn[b]}, cnt[b], int'(v.e[b]));
    chk({v.nm, ".first_valid"}, fv, v.fv);
    chk({v.nm, ".last_valid"}, lv, v.lv);
    chk({v.nm, ".busy_gap"}, gap, 0);
    chkv({v.nm, ".probe1"}, p1, v.p1v);
    chkv({v.nm, ".probe2"}, p2, v.p2v);
    chk({v.nm, ".cfg"}, int'(cfg), int'({v.k3, v.st}));
    if (!seen) begin
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
    end else if (v.sad) begin
      cfg_kernel3 = v.k3; cfg_stride = v.st; cfg_words_per_row = v.w; cfg_out_rows = v.r;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      act = 0;
      repeat (3) begin
        @(negedge clk);
        if (busy || done || ctrl != '0) act++;
      end
      chk({v.nm, ".start_at_done"}, act, 0);
    end else begin
      @(negedge clk);
      chk({v.nm, ".done_pulse"}, int'(done), 0);
    end
  endtask
  initial begin
    int d;
    vecs.push_back(mk("basic2x2", 1'b0, 2'd2, 4'd3, 6'd2, 2'd0, 0, 0, 0, 0, 41,
      {8'd0, 8'd12, 8'd12, 8'd12, 8'd12, 8'd12, 8'd12}, 15, 40, 2, 7'b0000010, 6, 7'b0010100, 1'b0));
    vecs.push_back(mk("k3s1", 1'b1, 2'd1, 4'd2, 6'd1, 2'd0, 0, 0, 0, 0, 35,
      {8'd0, 8'd8, 8'd8, 8'd16, 8'd16, 8'd6, 8'd18}, 26, 34, 26, 7'b0101001, 15, 7'b0001001, 1'b0));
    vecs.push_back(mk("k2s1", 1'b0, 2'd1, 4'd1, 6'd3, 2'd0, 0, 0, 0, 0, 35,
      {8'd0, 8'd12, 8'd12, 8'd12, 8'd12, 8'd6, 8'd18}, 11, 34, 11, 7'b0101001, 12, 7'b0101011, 1'b0));
    vecs.push_back(mk("k3s2", 1'b1, 2'd2, 4'd1, 6'd1, 2'd0, 0, 0, 0, 0, 14,
      {8'd0, 8'd2, 8'd2, 8'd4, 8'd4, 8'd3, 8'd3}, 12, 13, 9, 7'b0000100, 10, 7'b0001100, 1'b1));
    vecs.push_back(mk("zero_words", 1'b0, 2'd2, 4'd0, 6'd2, 2'd0, 0, 0, 0, 0, 1,
      '0, 0, 0, 1, 7'b0, 1, 7'b0, 1'b0));
    vecs.push_back(mk("zero_rows", 1'b1, 2'd1, 4'd3, 6'd0, 2'd0, 0, 0, 0, 0, 1,
      '0, 0, 0, 1, 7'b0, 1, 7'b0, 1'b0));
    vecs.push_back(mk("bp_pool", 1'b0, 2'd2, 4'd3, 6'd2, 2'd0, 4, 8, 0, 0, 46,
      {8'd0, 8'd12, 8'd12, 8'd12, 8'd12, 8'd12, 8'd12}, 20, 45, 9, 7'b0, 10, 7'b0000010, 1'b0));
    vecs.push_back(mk("bp_out", 1'b0, 2'd2, 4'd3, 6'd2, 2'd0, 0, 0, 4, 8, 46,
      {8'd0, 8'd12, 8'd12, 8'd12, 8'd12, 8'd12, 8'd12}, 20, 45, 9, 7'b0, 10, 7'b0000010, 1'b0));
    vecs.push_back(mk("mid_word_drop", 1'b0, 2'd2, 4'd3, 6'd2, 2'd0, 2, 3, 0, 0, 41,
      {8'd0, 8'd12, 8'd12, 8'd12, 8'd12, 8'd12, 8'd12}, 15, 40, 2, 7'b0000010, 6, 7'b0010100, 1'b0));
    vecs.push_back(mk("bp_first_word", 1'b1, 2'd1, 4'd2, 6'd1, 2'd0, 0, 0, 1, 3, 38,
      {8'd0, 8'd8, 8'd8, 8'd16, 8'd16, 8'd6, 8'd18}, 29, 37, 4, 7'b0, 5, 7'b0000010, 1'b0));
`ifdef POOL_CTRL_PAD_EN
    vecs.push_back(mk("pad_row", 1'b1, 2'd2, 4'd1, 6'd1, 2'd1, 7, 60, 0, 0, 14,
      {8'd2, 8'd2, 8'd2, 8'd4, 8'd4, 8'd3, 8'd3}, 12, 13, 8, 7'b1001011, 9, 7'b1000100, 1'b0));
`endif
    repeat (3) @(negedge clk);
    chkv("reset.ctrl", ctrl, 7'b0);
    chk("reset.busy", int'(busy), 0);
    reset = 1'b1;
    @(negedge clk);
    chkv("idle.ctrl", ctrl, 7'b0);
    chk("idle.cfg", int'(cfg), 0);
    chk("idle.busy", int'(busy), 0);
    chk("idle.done", int'(done), 0);
    foreach (vecs[i]) run(vecs[i]);
    cfg_kernel3 = 1'b0; cfg_stride = 2'd2; cfg_words_per_row = 4'd3; cfg_out_rows = 6'd2; cfg_pad_rows = 2'd0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    chkv("rst_mid.pre_ctrl", ctrl, 7'b0000011);
    reset = 1'b0;
    #1 chkv("rst_mid.ctrl", ctrl, 7'b0);
    chk("rst_mid.busy", int'(busy), 0);
    d = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) d++;
    end
    chk("rst_mid.no_done", d, 0);
    chk("rst_mid.cfg", int'(cfg), 0);
    reset = 1'b1;
    @(negedge clk);
    run(vecs[0]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end
endmodule
